id_ex_alu_issue: RTL and testbench
==================================

Name: id_ex_alu_issue

Overview:
Decode-side producer for the EX-stage ALU interface of the RISC-V pipeline. It takes decoded instruction fields plus register-file read data, generates the 4-bit ALU control code, operand B selection and immediates, and registers everything into the ID/EX pipeline stage. Valid/ready handshakes sit on both sides, with a flush input for branch mispredict and trap squash. The EX stage consumes the outputs directly as ALU A/B/ALUCtl plus control bits.

Parameters:
XLEN, 32, datapath width of operands and immediates
REG_AW, 5, register index width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID has an instruction
id_ready  out  1  stage accepts this cycle
id_inst  in  32  raw instruction word
id_rs1_data  in  XLEN  register-file read port 1
id_rs2_data  in  XLEN  register-file read port 2
flush  in  1  squash stage contents
ex_valid  out  1  stage holds an instruction
ex_ready  in  1  EX consumes this cycle
ex_a  out  XLEN  ALU operand A
ex_b  out  XLEN  ALU operand B
ex_aluctl  out  4  ALU control code
ex_imm  out  XLEN  sign-extended immediate (I/S/B per type)
ex_rs2_data  out  XLEN  store data
ex_rd  out  REG_AW  destination register
ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1 each  control bits
ex_br_on_zero  out  1  branch taken when ALU zero==1 (else when zero==0)
ex_illegal  out  1  unsupported encoding

Behaviour:
- ALUCtl codes: ADD 0000, SUB 0001, SLT 0010, OR 0011, AND 0100, SLTU 0101.
- R-type 0110011, funct7=0000000: f3 000 ADD, 010 SLT, 011 SLTU, 110 OR, 111 AND. funct7=0100000 with f3 000 gives SUB. B=rs2. regwrite=1.
- I-ALU 0010011: f3 000/010/011/110/111 map to ADD/SLT/SLTU/OR/AND. B=imm_i (inst[31:20] sign-extended). regwrite=1.
- LW 0000011 f3=010: ADD, B=imm_i, memread=1, regwrite=1.
- SW 0100011 f3=010: ADD, B=imm_s, memwrite=1, rd output forced 0.
- Branch 1100011, B=rs2, branch=1, ex_imm=imm_b:
  - BEQ: SUB, br_on_zero=1. BNE: SUB, br_on_zero=0.
  - BLT: SLT, br_on_zero=0. BGE: SLT, br_on_zero=1.
  - BLTU: SLTU, br_on_zero=0. BGEU: SLTU, br_on_zero=1.
- Any other opcode/funct: ex_illegal=1, aluctl=0000, all control bits 0, still passed downstream.
- ex_a = rs1 data in all cases.
- Handshake:
  - id_ready = !flush && (!ex_valid || ex_ready).
  - Transfer when id_valid && id_ready; all payload registers load and ex_valid<=1. Latency is 1 cycle.
  - If ex_valid && ex_ready with no transfer, ex_valid<=0.
  - While ex_valid && !ex_ready, payload is held stable.
- Flush: ex_valid<=0 next edge, regardless of ex_ready or id_valid. No transfer occurs in a flush cycle. Payload is not cleared.
- Reset (async): ex_valid=0, all payload outputs 0. Reset mid-stall discards the held instruction.

Optional Feature:
FWD_EN.
- Defined: adds input ports mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data.
  - Operand source for rs1 (inst[19:15]) and rs2 (inst[24:20]), sampled at transfer: MEM match first, then WB match, else register file.
  - A match requires we=1, rd==index and index!=0.
- Undefined: these ports are absent; register-file data is used directly.

Decomposition:
- Package riscv_pkg: opcode constants, ALUCtl localparams (shared with the ALU), funct3 branch codes.
- Natural sub-module: alu_ctl_decode, purely combinational inst to {aluctl, bsel, imm, control bits, illegal}.
- The top level holds the pipeline register, handshake and forwarding muxes.

Test Plan:
- Reset, then add x3,x1,x2 with rs1=5, rs2=7 → one cycle later ex_valid=1, a=5, b=7, aluctl=0000, rd=3, regwrite=1.
- addi x1,x0,-1 (inst 0xFFF00093) → b=0xFFFFFFFF, aluctl=0000. bgeu → aluctl=0101, branch=1, br_on_zero=1, imm_b correct.
- ex_ready=0 for 3 cycles with id_valid=1 → id_ready=0, outputs stable. ex_ready=1 → next instruction loads the following cycle, with no loss or duplication.
- flush asserted while ex_valid=1 and id_valid=1 → ex_valid=0 next cycle, id_ready=0 during flush.
- xor (f3=100, R-type) → ex_illegal=1, aluctl=0000, regwrite=memread=memwrite=branch=0.
- FWD_EN: sub with rs1=x4, mem_fwd(we=1, rd=4, 0x10) and wb_fwd(we=1, rd=4, 0x20) → a=0x10. With rd=0 in both, the register-file value is used.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared RV32I opcode, funct and ALU control constants for ID/EX.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic br_on_zero;
    logic illegal;
  } ctrl_t;

  // Returns {supported, aluctl} for the funct3 space shared by R-type and I-ALU.
  function automatic logic [4:0] alu_f3_decode(input logic [2:0] f3);
    logic [4:0] r;
    case (f3)
      F3_ADD:  r = {1'b1, ALU_ADD};
      F3_SLT:  r = {1'b1, ALU_SLT};
      F3_SLTU: r = {1'b1, ALU_SLTU};
      F3_OR:   r = {1'b1, ALU_OR};
      F3_AND:  r = {1'b1, ALU_AND};
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_ctl_decode.sv
// ============================================================================
// Module : alu_ctl_decode
// Brief  : Combinational instruction decode to ALU control, B select, imm, ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_ctl_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [3:0]      aluctl_o,
  output logic            bsel_o,
  output logic [XLEN-1:0] imm_o,
  output ctrl_t           ctrl_o
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [4:0]      f3_dec;
  logic            unused_rs1_field;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];
  assign f3_dec = alu_f3_decode(f3);
  assign unused_rs1_field = ^inst_i[19:15];

  assign imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

  always_comb begin
    aluctl_o = ALU_ADD;
    bsel_o   = 1'b0;
    imm_o    = '0;
    ctrl_o   = '0;
    case (opcode)
      OP_RTYPE: begin
        if (f7 == F7_BASE && f3_dec[4]) begin
          aluctl_o        = f3_dec[3:0];
          ctrl_o.regwrite = 1'b1;
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          aluctl_o        = ALU_SUB;
          ctrl_o.regwrite = 1'b1;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      OP_IALU: begin
        if (f3_dec[4]) begin
          aluctl_o        = f3_dec[3:0];
          bsel_o          = 1'b1;
          imm_o           = imm_i;
          ctrl_o.regwrite = 1'b1;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        if (f3 == F3_WORD) begin
          bsel_o          = 1'b1;
          imm_o           = imm_i;
          ctrl_o.memread  = 1'b1;
          ctrl_o.regwrite = 1'b1;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      OP_STORE: begin
        if (f3 == F3_WORD) begin
          bsel_o          = 1'b1;
          imm_o           = imm_s;
          ctrl_o.memwrite = 1'b1;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        ctrl_o.branch = 1'b1;
        imm_o         = imm_b;
        case (f3)
          F3_BEQ:  begin aluctl_o = ALU_SUB;  ctrl_o.br_on_zero = 1'b1; end
          F3_BNE:  begin aluctl_o = ALU_SUB;  ctrl_o.br_on_zero = 1'b0; end
          F3_BLT:  begin aluctl_o = ALU_SLT;  ctrl_o.br_on_zero = 1'b0; end
          F3_BGE:  begin aluctl_o = ALU_SLT;  ctrl_o.br_on_zero = 1'b1; end
          F3_BLTU: begin aluctl_o = ALU_SLTU; ctrl_o.br_on_zero = 1'b0; end
          F3_BGEU: begin aluctl_o = ALU_SLTU; ctrl_o.br_on_zero = 1'b1; end
          default: begin
            ctrl_o.branch  = 1'b0;
            ctrl_o.illegal = 1'b1;
            imm_o          = '0;
          end
        endcase
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_alu_issue.sv
// ============================================================================
// Module : id_ex_alu_issue
// Brief  : ID/EX pipeline register feeding the EX ALU, valid/ready + flush.
//          Optional operand forwarding from MEM/WB under macro FWD_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_alu_issue
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       id_inst,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [3:0]        ex_aluctl,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic              ex_br_on_zero,
  output logic              ex_illegal
`ifdef FWD_EN
  ,
  input  logic              mem_fwd_we,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_fwd_we,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data
`endif
);

  logic [3:0]      dec_aluctl;
  logic            dec_bsel;
  logic [XLEN-1:0] dec_imm;
  ctrl_t           dec_ctrl;

  alu_ctl_decode #(.XLEN(XLEN)) u_dec (
    .inst_i   (id_inst),
    .aluctl_o (dec_aluctl),
    .bsel_o   (dec_bsel),
    .imm_o    (dec_imm),
    .ctrl_o   (dec_ctrl)
  );

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_rs2;

`ifdef FWD_EN
  logic [REG_AW-1:0] rs1_idx;
  logic [REG_AW-1:0] rs2_idx;
  assign rs1_idx = REG_AW'(id_inst[19:15]);
  assign rs2_idx = REG_AW'(id_inst[24:20]);

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    op_a = id_rs1_data;
    if (rs1_idx != '0 && mem_fwd_we && mem_fwd_rd == rs1_idx)     op_a = mem_fwd_data;
    else if (rs1_idx != '0 && wb_fwd_we && wb_fwd_rd == rs1_idx)  op_a = wb_fwd_data;
    op_rs2 = id_rs2_data;
    if (rs2_idx != '0 && mem_fwd_we && mem_fwd_rd == rs2_idx)     op_rs2 = mem_fwd_data;
    else if (rs2_idx != '0 && wb_fwd_we && wb_fwd_rd == rs2_idx)  op_rs2 = wb_fwd_data;
  end
`else
  assign op_a   = id_rs1_data;
  assign op_rs2 = id_rs2_data;
`endif

  logic            valid_q,  valid_d;
  logic [XLEN-1:0] a_q,      a_d;
  logic [XLEN-1:0] b_q,      b_d;
  logic [3:0]      aluctl_q, aluctl_d;
  logic [XLEN-1:0] imm_q,    imm_d;
  logic [XLEN-1:0] rs2_q,    rs2_d;
  logic [REG_AW-1:0] rd_q,   rd_d;
  ctrl_t           ctrl_q,   ctrl_d;
  logic            xfer;

  assign id_ready = !flush && (!valid_q || ex_ready);
  assign xfer     = id_valid && id_ready;

  always_comb begin
    valid_d  = valid_q;
    a_d      = a_q;
    b_d      = b_q;
    aluctl_d = aluctl_q;
    imm_d    = imm_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    ctrl_d   = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (xfer) begin
      valid_d  = 1'b1;
      a_d      = op_a;
      b_d      = dec_bsel ? dec_imm : op_rs2;
      aluctl_d = dec_aluctl;
      imm_d    = dec_imm;
      rs2_d    = op_rs2;
      rd_d     = dec_ctrl.memwrite ? '0 : REG_AW'(id_inst[11:7]);
      ctrl_d   = dec_ctrl;
    end else if (valid_q && ex_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      aluctl_q <= '0;
      imm_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluctl_q <= aluctl_d;
      imm_q    <= imm_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_a          = a_q;
  assign ex_b          = b_q;
  assign ex_aluctl     = aluctl_q;
  assign ex_imm        = imm_q;
  assign ex_rs2_data   = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_regwrite   = ctrl_q.regwrite;
  assign ex_memread    = ctrl_q.memread;
  assign ex_memwrite   = ctrl_q.memwrite;
  assign ex_branch     = ctrl_q.branch;
  assign ex_br_on_zero = ctrl_q.br_on_zero;
  assign ex_illegal    = ctrl_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_alu_issue.sv
// ============================================================================
// Module : tb_id_ex_alu_issue
// Brief  : Directed scoreboard bench for id_ex_alu_issue (FWD_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_alu_issue;

  logic        clk, rst;
  logic        id_valid, id_ready, flush, ex_valid, ex_ready;
  logic [31:0] id_inst, id_rs1_data, id_rs2_data;
  logic [31:0] ex_a, ex_b, ex_imm, ex_rs2_data;
  logic [3:0]  ex_aluctl;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_br_on_zero, ex_illegal;
`ifdef FWD_EN
  logic        mem_fwd_we, wb_fwd_we;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
`endif

  id_ex_alu_issue #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b),
    .ex_aluctl(ex_aluctl), .ex_imm(ex_imm), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_br_on_zero(ex_br_on_zero), .ex_illegal(ex_illegal)
`ifdef FWD_EN
    , .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl order: {regwrite, memread, memwrite, branch, br_on_zero, illegal}
  typedef struct {
    logic [31:0] a, b, imm, rs2;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic [5:0]  ctrl;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   m_valid;
  int   checks, failures;

  function automatic exp_t mk(logic [31:0] a, logic [31:0] b, logic [3:0] ctl,
                              logic [31:0] imm, logic [31:0] rs2, logic [4:0] rd,
                              logic [5:0] ctrl);
    exp_t e;
    e.a = a; e.b = b; e.ctl = ctl; e.imm = imm; e.rs2 = rs2; e.rd = rd; e.ctrl = ctrl;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input logic [31:0] inst, input logic [31:0] r1,
                        input logic [31:0] r2, input exp_t e);
    id_valid = v; id_inst = inst; id_rs1_data = r1; id_rs2_data = r2; pend = e;
  endtask

  task automatic check_out(input string tag);
    exp_t f;
    chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, m_valid});
    if (m_valid) begin
      if (q.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
        f = q[0];
        chk({tag, ".a"},      ex_a, f.a);
        chk({tag, ".b"},      ex_b, f.b);
        chk({tag, ".aluctl"}, {28'd0, ex_aluctl}, {28'd0, f.ctl});
        chk({tag, ".imm"},    ex_imm, f.imm);
        chk({tag, ".rs2"},    ex_rs2_data, f.rs2);
        chk({tag, ".rd"},     {27'd0, ex_rd}, {27'd0, f.rd});
        chk({tag, ".ctrl"},
            {26'd0, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_br_on_zero, ex_illegal},
            {26'd0, f.ctrl});
      end
    end
  endtask

  task automatic cycle(input string tag);
    bit exp_rdy, xfer;
    #1;
    exp_rdy = !flush && (!m_valid || ex_ready);
    chk({tag, ".id_ready"}, {31'd0, id_ready}, {31'd0, exp_rdy});
    xfer = id_valid && exp_rdy;
    @(posedge clk);
    if (flush) begin
      if (m_valid) void'(q.pop_front());
      m_valid = 1'b0;
    end else if (xfer) begin
      if (m_valid) void'(q.pop_front());
      q.push_back(pend);
      m_valid = 1'b1;
    end else if (m_valid && ex_ready) begin
      void'(q.pop_front());
      m_valid = 1'b0;
    end
    #1;
    check_out(tag);
  endtask

  exp_t nil;

  initial begin
    checks = 0; failures = 0; m_valid = 1'b0;
    nil = mk(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, nil);
`ifdef FWD_EN
    mem_fwd_we = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", {31'd0, ex_valid}, 32'd0);
    chk("reset.a", ex_a, 32'd0);
    chk("reset.b", ex_b, 32'd0);
    chk("reset.imm", ex_imm, 32'd0);
    chk("reset.rd", {27'd0, ex_rd}, 32'd0);
    chk("reset.ctrl", {26'd0, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
                       ex_br_on_zero, ex_illegal}, 32'd0);
    rst = 1'b0;

    set_in(1, 32'h002081B3, 32'd5, 32'd7, mk(5, 7, 4'b0000, 0, 7, 3, 6'b100000));
    cycle("add");
    set_in(0, 32'h0, 32'h0, 32'h0, nil);
    cycle("idle0");
    set_in(1, 32'hFFF00093, 32'd0, 32'h55, mk(0, 32'hFFFFFFFF, 4'b0000, 32'hFFFFFFFF, 32'h55, 1, 6'b100000));
    cycle("addi");
    set_in(1, 32'hFE20FCE3, 32'h11, 32'h22, mk(32'h11, 32'h22, 4'b0101, 32'hFFFFFFF8, 32'h22, 25, 6'b000110));
    cycle("bgeu");

    set_in(1, 32'h0020A623, 32'h1000, 32'hDEAD, mk(32'h1000, 12, 4'b0000, 12, 32'hDEAD, 0, 6'b001000));
    cycle("sw");
    set_in(1, 32'hFFC0A283, 32'h2000, 32'h3, mk(32'h2000, 32'hFFFFFFFC, 4'b0000, 32'hFFFFFFFC, 3, 5, 6'b110000));
    ex_ready = 1'b0;
    cycle("stall1");
    cycle("stall2");
    cycle("stall3");
    ex_ready = 1'b1;
    cycle("lw");
    set_in(1, 32'h40208333, 32'd9, 32'd4, mk(9, 4, 4'b0001, 0, 4, 6, 6'b100000));
    cycle("sub");

    set_in(1, 32'h0020C3B3, 32'hA, 32'hB, mk(32'hA, 32'hB, 4'b0000, 0, 32'hB, 7, 6'b000001));
    flush = 1'b1;
    cycle("flush");
    flush = 1'b0;
    cycle("xor");
    set_in(1, 32'h00208463, 32'd1, 32'd1, mk(1, 1, 4'b0001, 8, 1, 8, 6'b000110));
    cycle("beq");
    set_in(1, 32'h0050A493, 32'hFFFFFFFD, 32'h77, mk(32'hFFFFFFFD, 5, 4'b0010, 5, 32'h77, 9, 6'b100000));
    cycle("slti");
    set_in(0, 32'h0, 32'h0, 32'h0, nil);
    cycle("drain");

`ifdef FWD_EN
    mem_fwd_we = 1; mem_fwd_rd = 4; mem_fwd_data = 32'h10;
    wb_fwd_we = 1;  wb_fwd_rd = 4;  wb_fwd_data = 32'h20;
    set_in(1, 32'h405200B3, 32'h99, 32'h88, mk(32'h10, 32'h88, 4'b0001, 0, 32'h88, 1, 6'b100000));
    cycle("fwd_mem");
    mem_fwd_rd = 6; wb_fwd_rd = 5; wb_fwd_data = 32'h30;
    set_in(1, 32'h405200B3, 32'h99, 32'h88, mk(32'h99, 32'h30, 4'b0001, 0, 32'h30, 1, 6'b100000));
    cycle("fwd_wb");
    mem_fwd_rd = 0; wb_fwd_rd = 0;
    set_in(1, 32'h400000B3, 32'h44, 32'h33, mk(32'h44, 32'h33, 4'b0001, 0, 32'h33, 1, 6'b100000));
    cycle("fwd_x0");
    mem_fwd_we = 0; wb_fwd_we = 0;
    set_in(0, 32'h0, 32'h0, 32'h0, nil);
    cycle("fwd_drain");
`endif

    set_in(1, 32'h002081B3, 32'd5, 32'd7, mk(5, 7, 4'b0000, 0, 7, 3, 6'b100000));
    cycle("pre_rst");
    set_in(0, 32'h0, 32'h0, 32'h0, nil);
    ex_ready = 1'b0;
    cycle("hold");
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_valid = 1'b0;
    chk("midrst.valid", {31'd0, ex_valid}, 32'd0);
    chk("midrst.a", ex_a, 32'd0);
    chk("midrst.rd", {27'd0, ex_rd}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ex_ready = 1'b1;
    cycle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
